// File: rtl/wb_regs_if.sv
// ============================================================================
// Interface : wb_regs_if
// Purpose   : Bus bundle between the ex/id stages and the write-back register
//             file. Debug-port signals exist only when REGS_DBG_PORT_EN is
//             defined.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_regs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 64
);
    // ex-stage result
    logic [ADDR_W-1:0] rd_addr_i;
    logic [DATA_W-1:0] rd_data_i;
    logic              rd_wen_i;
    // id-stage read ports
    logic [ADDR_W-1:0] reg1_raddr_i;
    logic [ADDR_W-1:0] reg2_raddr_i;
    logic [DATA_W-1:0] reg1_rdata_o;
    logic [DATA_W-1:0] reg2_rdata_o;
    // committed-write counter
    logic [CNT_W-1:0]  wb_cnt_o;

`ifdef REGS_DBG_PORT_EN
    // debug access port
    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic              dbg_ack_o;
    logic [DATA_W-1:0] dbg_rdata_o;

    modport master (
        output rd_addr_i, rd_data_i, rd_wen_i, reg1_raddr_i, reg2_raddr_i,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  reg1_rdata_o, reg2_rdata_o, wb_cnt_o, dbg_ack_o, dbg_rdata_o
    );
    modport slave (
        input  rd_addr_i, rd_data_i, rd_wen_i, reg1_raddr_i, reg2_raddr_i,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output reg1_rdata_o, reg2_rdata_o, wb_cnt_o, dbg_ack_o, dbg_rdata_o
    );
`else
    modport master (
        output rd_addr_i, rd_data_i, rd_wen_i, reg1_raddr_i, reg2_raddr_i,
        input  reg1_rdata_o, reg2_rdata_o, wb_cnt_o
    );
    modport slave (
        input  rd_addr_i, rd_data_i, rd_wen_i, reg1_raddr_i, reg2_raddr_i,
        output reg1_rdata_o, reg2_rdata_o, wb_cnt_o
    );
`endif

endinterface

`default_nettype wire

// File: rtl/wb_regs.sv
// ============================================================================
// Module    : wb_regs
// Purpose   : Write-back pipeline register plus integer register file with
//             ex/WB forwarding on both read ports and a committed-write
//             counter. Optional debug access port enabled by defining
//             REGS_DBG_PORT_EN.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regs #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int CNT_W   = 64
) (
    input  wire logic clk,
    input  wire logic rst_n,
    wb_regs_if.slave  bus
);

    localparam int ADDR_W = $clog2(REG_NUM);

    logic [DATA_W-1:0] regs [REG_NUM];
    logic              wb_wen_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [CNT_W-1:0]  wb_cnt_q;

    // debug write strobe into the array (tied off without the debug port)
    logic              dbg_wr;
    logic [ADDR_W-1:0] dbg_wr_addr;
    logic [DATA_W-1:0] dbg_wr_data;

    // Youngest producer wins: ex result, then WB register, then the array.
    function automatic logic [DATA_W-1:0] fwd_read(
        input logic [ADDR_W-1:0] addr,
        input logic              ex_wen,
        input logic [ADDR_W-1:0] ex_addr,
        input logic [DATA_W-1:0] ex_data,
        input logic              wbk_wen,
        input logic [ADDR_W-1:0] wbk_addr,
        input logic [DATA_W-1:0] wbk_data,
        input logic [DATA_W-1:0] arr_data
    );
        logic [DATA_W-1:0] val;
        if (addr == '0)
            val = '0;
        else if (ex_wen && ex_addr == addr)
            val = ex_data;
        else if (wbk_wen && wbk_addr == addr)
            val = wbk_data;
        else
            val = arr_data;
        return val;
    endfunction

    // WB pipeline register; x0 writes are dropped here so they never commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_wen_q  <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wb_addr_q <= bus.rd_addr_i;
            wb_data_q <= bus.rd_data_i;
            wb_wen_q  <= bus.rd_wen_i && (bus.rd_addr_i != '0);
        end
    end

    // Register array: pipeline commit is applied last so it overrides a debug write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (dbg_wr)
                regs[dbg_wr_addr] <= dbg_wr_data;
            if (wb_wen_q)
                regs[wb_addr_q] <= wb_data_q;
        end
    end

    // Committed-write counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wb_cnt_q <= '0;
        else if (wb_wen_q)
            wb_cnt_q <= wb_cnt_q + CNT_W'(1);
    end

    assign bus.wb_cnt_o = wb_cnt_q;

    // Read ports are held at zero while reset is asserted
    assign bus.reg1_rdata_o = !rst_n ? '0 :
        fwd_read(bus.reg1_raddr_i, bus.rd_wen_i, bus.rd_addr_i, bus.rd_data_i,
                 wb_wen_q, wb_addr_q, wb_data_q, regs[bus.reg1_raddr_i]);
    assign bus.reg2_rdata_o = !rst_n ? '0 :
        fwd_read(bus.reg2_raddr_i, bus.rd_wen_i, bus.rd_addr_i, bus.rd_data_i,
                 wb_wen_q, wb_addr_q, wb_data_q, regs[bus.reg2_raddr_i]);

`ifdef REGS_DBG_PORT_EN
    typedef enum logic [1:0] {
        DBG_IDLE = 2'd0,
        DBG_WAIT = 2'd1,
        DBG_ACK  = 2'd2
    } dbg_state_t;

    dbg_state_t        dbg_state;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
    logic              pipe_busy;
    logic              dbg_fire;
    logic [DATA_W-1:0] dbg_fwd;

    // A debug write must not race an in-flight pipeline write
    assign pipe_busy = wb_wen_q || bus.rd_wen_i;

    assign dbg_fwd = fwd_read(bus.dbg_addr_i, bus.rd_wen_i, bus.rd_addr_i, bus.rd_data_i,
                              wb_wen_q, wb_addr_q, wb_data_q, regs[bus.dbg_addr_i]);

    // Decide whether the debug access is performed on this edge
    always_comb begin
        dbg_fire = 1'b0;
        case (dbg_state)
            DBG_IDLE: dbg_fire = bus.dbg_req_i && !(bus.dbg_we_i && pipe_busy);
            DBG_WAIT: dbg_fire = bus.dbg_req_i && !pipe_busy;
            default:  dbg_fire = 1'b0;
        endcase
    end

    assign dbg_wr      = dbg_fire && bus.dbg_we_i && (bus.dbg_addr_i != '0);
    assign dbg_wr_addr = bus.dbg_addr_i;
    assign dbg_wr_data = bus.dbg_wdata_i;

    // Debug FSM: capture read data on access, pulse ack for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_state <= DBG_IDLE;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= 1'b0;
            case (dbg_state)
                DBG_IDLE: begin
                    if (dbg_fire) begin
                        dbg_rdata <= dbg_fwd;
                        dbg_ack   <= 1'b1;
                        dbg_state <= DBG_ACK;
                    end else if (bus.dbg_req_i) begin
                        dbg_state <= DBG_WAIT;
                    end
                end
                DBG_WAIT: begin
                    if (!bus.dbg_req_i) begin
                        dbg_state <= DBG_IDLE;
                    end else if (dbg_fire) begin
                        dbg_rdata <= dbg_fwd;
                        dbg_ack   <= 1'b1;
                        dbg_state <= DBG_ACK;
                    end
                end
                DBG_ACK:  dbg_state <= DBG_IDLE;
                default:  dbg_state <= DBG_IDLE;
            endcase
        end
    end

    assign bus.dbg_ack_o   = dbg_ack;
    assign bus.dbg_rdata_o = dbg_rdata;
`else
    assign dbg_wr      = 1'b0;
    assign dbg_wr_addr = '0;
    assign dbg_wr_data = '0;
`endif

endmodule

`default_nettype wire
